// File: rtl/i2c_target_responder.sv
// I2C target that ACKs TARGET_ADDR, hands written bytes to the fabric as rx strobes
// and fetches each read byte from the fabric through a one-clk tx_req handshake.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } state_t;

    state_t     state;
    logic       scl_meta, scl_sync, scl_prev;
    logic       sda_meta, sda_sync, sda_prev;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       read_mode;

    logic scl_rise, scl_fall, start_cond, stop_cond;

    // Sync flops reset to the idle-high bus level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    assign scl_rise   = scl_sync & ~scl_prev;
    assign scl_fall   = ~scl_sync & scl_prev;
    assign start_cond = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_cond  = scl_sync & scl_prev & ~sda_prev & sda_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'd0;
            read_mode <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_cond) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_cond) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    // Byte just shifted is {shift[6:0], sda_sync}, so the address is shift[6:0].
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_sync};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (shift[6:0] == TARGET_ADDR) begin
                                    busy      <= 1'b1;
                                    read_mode <= sda_sync;
                                    tx_req    <= sda_sync;
                                    state     <= ADDR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // First fall here starts the ACK; a fall while already driving ends it.
                    ADDR_ACK, WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= 4'd0;
                                if (state == ADDR_ACK && read_mode) begin
                                    sda_oe <= ~tx_data[7];
                                    shift  <= {tx_data[6:0], 1'b0};
                                    state  <= READ;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= WRITE;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_sync};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {shift[6:0], sda_sync};
                                rx_valid <= 1'b1;
                                state    <= WRITE_ACK;
                            end
                        end
                    end
                    READ: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= READ_ACK;
                            end else begin
                                sda_oe <= ~shift[7];
                                shift  <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    // Only an ACKed 9th rise can lead to a fall in this state.
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync) begin
                                sda_oe <= 1'b0;
                                state  <= WAIT_STOP;
                            end else begin
                                tx_req <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= ~tx_data[7];
                            shift   <= {tx_data[6:0], 1'b0};
                            state   <= READ;
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-banged I2C master on a wired-AND SDA bus,
// table-driven write transactions plus hand-written read, Sr, abort and glitch sequences.
module tb_i2c_target_responder;
    localparam int Q = 10;

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data;
        logic       exp_ack;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl, m_sda, sda_bus;
    logic       sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data, tx_data;
    logic [7:0] last_rx = 8'h00;

    int n_cmp = 0;
    int n_fail = 0;
    int rx_count = 0;
    int tx_count = 0;
    int oe_cycles = 0;
    int both_count = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] rx_obs_q[$];
    vec_t vecs[6];

    assign sda_bus = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target_responder #(.TARGET_ADDR(7'h42)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (sda_oe) oe_cycles++;
        if (tx_req) tx_count++;
        if (rx_valid && tx_req) both_count++;
        if (rx_valid) begin
            rx_count++;
            rx_obs_q.push_back(rx_data);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b1; wait_clks(Q);
    endtask

    // With glitch set, SDA bounces while SCL is low before settling on the bit.
    task automatic send_bit(input logic b, input logic glitch, output logic seen);
        if (glitch) begin
            m_sda = ~b; wait_clks(2);
            m_sda = b;  wait_clks(2);
            m_sda = ~b; wait_clks(2);
        end
        m_sda = b;    wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        seen = sda_bus;
        wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic seen;
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch, seen);
        send_bit(1'b1, 1'b0, seen);
        ack = ~seen;
    endtask

    task automatic recv_byte(input logic master_ack, input logic [7:0] next_tx,
                             output logic [7:0] b, output logic ack_slot);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, seen);
            b[i] = seen;
        end
        tx_data = next_tx;
        send_bit(~master_ack, 1'b0, ack_slot);
    endtask

    task automatic drain_scoreboard();
        logic [7:0] got;
        while (rx_obs_q.size() > 0) begin
            got = rx_obs_q.pop_front();
            if (rx_exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL rx_unexpected: got 0x%0h, want no byte", got);
            end else begin
                check_output("rx_byte", 32'(got), 32'(rx_exp_q.pop_front()));
            end
        end
        check_output("rx_missing", 32'(rx_exp_q.size()), 32'd0);
        rx_exp_q.delete();
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic ack;
        int   rx_before, oe_before;
        rx_before = rx_count;
        oe_before = oe_cycles;
        if (v.exp_ack) begin
            rx_exp_q.push_back(v.data);
            last_rx = v.data;
        end
        i2c_start();
        send_byte(v.addr_byte, 1'b0, ack);
        check_output("addr_ack", 32'(ack), 32'(v.exp_ack));
        check_output("busy_in_txn", 32'(busy), 32'(v.exp_ack));
        send_byte(v.data, 1'b0, ack);
        check_output("data_ack", 32'(ack), 32'(v.exp_ack));
        i2c_stop();
        wait_clks(Q);
        check_output("busy_after_stop", 32'(busy), 32'd0);
        check_output("rx_pulses", 32'(rx_count - rx_before), v.exp_ack ? 32'd1 : 32'd0);
        check_output("rx_data", 32'(rx_data), 32'(last_rx));
        if (!v.exp_ack) check_output("oe_never", 32'(oe_cycles - oe_before), 32'd0);
        drain_scoreboard();
    endtask

    initial begin
        logic       ack, slot;
        logic [7:0] b;
        int         rx_before, tx_before, oe_mark;

        reset = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        tx_data = 8'h00;
        vecs[0] = '{8'h84, 8'hA5, 1'b1};
        vecs[1] = '{8'h86, 8'h11, 1'b0};
        vecs[2] = '{8'h84, 8'h00, 1'b1};
        vecs[3] = '{8'h84, 8'hFF, 1'b1};
        vecs[4] = '{8'h04, 8'h55, 1'b0};
        vecs[5] = '{8'hC4, 8'h3C, 1'b0};

        wait_clks(3);
        check_output("reset_sda_oe", 32'(sda_oe), 32'd0);
        check_output("reset_rx_data", 32'(rx_data), 32'd0);
        check_output("reset_rx_valid", 32'(rx_valid), 32'd0);
        check_output("reset_tx_req", 32'(tx_req), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        wait_clks(Q);

        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

        $display("[TB] two-byte read");
        tx_before = tx_count;
        tx_data = 8'h3C;
        i2c_start();
        send_byte(8'h85, 1'b0, ack);
        check_output("rd_addr_ack", 32'(ack), 32'd1);
        recv_byte(1'b1, 8'hC3, b, slot);
        check_output("rd_byte1", 32'(b), 32'h3C);
        oe_mark = 0;
        recv_byte(1'b0, 8'h00, b, slot);
        check_output("rd_byte2", 32'(b), 32'hC3);
        check_output("rd_nack_released", 32'(slot), 32'd1);
        oe_mark = oe_cycles;
        i2c_stop();
        wait_clks(Q);
        check_output("rd_oe_after_nack", 32'(oe_cycles - oe_mark), 32'd0);
        check_output("rd_tx_req_count", 32'(tx_count - tx_before), 32'd2);
        check_output("rd_busy_after_stop", 32'(busy), 32'd0);
        drain_scoreboard();

        $display("[TB] repeated start");
        rx_before = rx_count;
        rx_exp_q.push_back(8'h10);
        tx_data = 8'h96;
        i2c_start();
        send_byte(8'h84, 1'b0, ack);
        check_output("sr_wr_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h10, 1'b0, ack);
        check_output("sr_wr_data_ack", 32'(ack), 32'd1);
        i2c_start();
        send_byte(8'h85, 1'b0, ack);
        check_output("sr_rd_addr_ack", 32'(ack), 32'd1);
        recv_byte(1'b0, 8'h00, b, slot);
        check_output("sr_rd_byte", 32'(b), 32'h96);
        i2c_stop();
        wait_clks(Q);
        check_output("sr_rx_pulses", 32'(rx_count - rx_before), 32'd1);
        check_output("sr_rx_data", 32'(rx_data), 32'h10);
        drain_scoreboard();

        $display("[TB] reset during read bit 4");
        tx_data = 8'h00;
        i2c_start();
        send_byte(8'h85, 1'b0, ack);
        check_output("abort_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, slot);
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q / 2);
        check_output("abort_oe_before", 32'(sda_oe), 32'd1);
        reset = 1'b0;
        #1;
        check_output("abort_sda_oe", 32'(sda_oe), 32'd0);
        check_output("abort_rx_data", 32'(rx_data), 32'd0);
        check_output("abort_rx_valid", 32'(rx_valid), 32'd0);
        check_output("abort_tx_req", 32'(tx_req), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clks(4);
        reset = 1'b1;
        wait_clks(Q);

        $display("[TB] stop during write bit 5");
        rx_before = rx_count;
        rx_exp_q.push_back(8'h5A);
        i2c_start();
        send_byte(8'h84, 1'b0, ack);
        send_byte(8'h5A, 1'b0, ack);
        check_output("stop_mid_data_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, slot);
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b1; wait_clks(Q);
        wait_clks(Q);
        check_output("stop_mid_busy", 32'(busy), 32'd0);
        check_output("stop_mid_rx_pulses", 32'(rx_count - rx_before), 32'd1);
        check_output("stop_mid_rx_data", 32'(rx_data), 32'h5A);
        drain_scoreboard();

        $display("[TB] SDA glitches while SCL low");
        rx_exp_q.push_back(8'h3B);
        i2c_start();
        send_byte(8'h84, 1'b0, ack);
        check_output("glitch_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h3B, 1'b1, ack);
        check_output("glitch_data_ack", 32'(ack), 32'd1);
        check_output("glitch_busy", 32'(busy), 32'd1);
        i2c_stop();
        wait_clks(Q);
        check_output("glitch_rx_data", 32'(rx_data), 32'h3B);
        drain_scoreboard();

        check_output("rx_tx_same_clk", 32'(both_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) responder; the far end of the team's I2C master and its clock divider.
- Oversamples the bus SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and moves data bytes.
- Write data goes to the fabric as byte strobes. Read data is fetched from the fabric by a per-byte request pulse.
- Sits between the BASYS3 Pmod I2C pins (open-drain, external pull-ups) and user logic.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this block responds to.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl_in  input  1  raw bus SCL; asynchronous to clk.
- sda_in  input  1  raw bus SDA; asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low, 0 = release. Top level ties the pad to 0 when enabled.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  next byte to send on a read.
- tx_req  output  1  one-clk pulse requesting tx_data for the next read byte.
- busy  output  1  high from address match until STOP or abandonment.

Behaviour:
- Reset (reset=0, async): sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0. State goes to IDLE and the bit counter clears. Reset mid-transfer releases SDA immediately.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop.
  - Edges are decoded from synchronized current/previous values.
  - Edge detection latency from the pin is 3 clk.
- START: sync SDA falls while sync SCL is high. Valid in any state, including repeated START. Action: go to ADDR, clear the bit counter, sda_oe=0.
- STOP: sync SDA rises while sync SCL is high. Valid in any state. Action: go to IDLE, sda_oe=0, busy=0.
- Timing rule:
  - Input bits are sampled on the SCL rising edge.
  - sda_oe changes only on the SCL falling edge, except on START, STOP or reset.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first on SCL rise.
    - After the 8th rise, if bits[7:1]==TARGET_ADDR: set busy and go to ADDR_ACK.
    - Otherwise go to WAIT_STOP; sda_oe stays 0.
    - If R/W=1 (match case): pulse tx_req on that same 8th-rise clk.
  - ADDR_ACK: sda_oe=1 from the 8th SCL fall to the 9th SCL fall. On the 9th fall:
    - R/W=0: sda_oe=0, go to WRITE.
    - R/W=1: load tx_data into the shift register and go to READ.
  - WRITE: shift 8 bits on SCL rise.
    - On the 8th rise: rx_data = assembled byte, rx_valid pulses for 1 clk, go to WRITE_ACK.
  - WRITE_ACK: sda_oe=1 from the 8th fall to the 9th fall, then WRITE again. Every written byte is ACKed; there is no back-pressure.
  - READ: on each SCL fall (first one being the ACK's 9th fall), sda_oe = ~shift[7], then shift left.
    - After the 8th data bit's fall-window, the 8th fall releases SDA (sda_oe=0).
    - Then go to READ_ACK.
  - READ_ACK: sample master SDA on the 9th rise.
    - 0 (ACK): pulse tx_req on that clk. On the 9th fall load tx_data, drive bit 7, go to READ.
    - 1 (NACK): go to WAIT_STOP, sda_oe=0.
  - WAIT_STOP: sda_oe=0, busy stays as is. Ignore traffic until STOP, which clears busy, or START, which goes to ADDR and clears busy.
- tx_data contract: tx_data must be stable from the tx_req pulse until the next SCL fall. Guaranteed at least SCL low/high time minus 3 clk.
- Bit counter: 4 bits; counts 0..8 per byte and clears on START and at each 9th fall.
- Simultaneous events: START/STOP take priority over SCL edge processing in the same clk. rx_valid and tx_req never assert in the same clk.
- STOP or START mid-byte: the partial byte is discarded; rx_valid does not pulse.

Test Plan:
- Write, TARGET_ADDR=7'h42: START, 0x84, 0xA5, STOP -> sda_oe=1 during both 9th bits; rx_data=0xA5; rx_valid exactly 1 pulse; busy 1 then 0 after STOP.
- Address mismatch: START, 0x86, 0x11, STOP -> sda_oe never asserted; rx_valid never pulses; busy stays 0.
- Read, two bytes: START, 0x85; tx_data=0x3C then 0xC3 on each tx_req -> SDA carries 0x3C then 0xC3 MSB first. Master ACKs byte 1 -> second tx_req; master NACKs byte 2 -> sda_oe=0 through STOP; tx_req total = 2.
- Repeated START: write 0x84, 0x10, then Sr, 0x85, read one byte with NACK, STOP -> rx_data=0x10 with one pulse; one ACK per address phase; read byte driven correctly.
- Mid-operation aborts: reset=0 during bit 4 of the read byte -> sda_oe=0 within the same clk and all outputs at reset values. STOP during bit 5 of a write byte -> IDLE, no rx_valid, rx_data unchanged.
- Glitch/sync check: SDA toggled while SCL is low mid-byte -> no false START/STOP; data unaffected.
